// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// States, opcodes, ALUOp and PCSrc codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    // Opcodes whose execute step uses the immediate as operand B.
    function automatic logic imm_operand(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory wait-state counter.
// Flags timeout once the count reaches MAX.
module mem_wait_timer #(
    parameter int MAX = 15
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [7:0] MAX_C = 8'(MAX);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= 8'd0;
        else         cnt_q <= cnt_d;
    end

    // Clear wins; saturate rather than wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = 8'd0;
        else if (en_i && cnt_q != 8'hFF)
            cnt_d = cnt_q + 8'd1;
    end

    assign timeout_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM.
// Sequences fetch/decode/execute/memory/write-back.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       ALUSrc,
    output logic [1:0] ALUOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       Trap,
    output logic [3:0] State
);

    state_e state_q;
    state_e state_d;
    logic   wait_st;
    logic   wait_en;
    logic   tmo;

    assign wait_st = (state_q == S_FETCH) ||
                     (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR);
    assign wait_en = wait_st && !Mem_Ready;

    mem_wait_timer #(
        .MAX(MEM_WAIT_MAX)
    ) u_timer (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .clr_i    (!wait_en),
        .en_i     (wait_en),
        .timeout_o(tmo)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (Mem_Ready)  state_d = S_DECODE;
                else if (tmo)   state_d = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    Opcode == OP_RTYPE: state_d = S_EXEC_R;
                    Opcode == OP_LW,
                    Opcode == OP_SW:    state_d = S_MEM_ADDR;
                    Opcode == OP_ADDI:  state_d = S_EXEC_I;
                    Opcode == OP_BEQ:   state_d = S_BRANCH;
                    Opcode == OP_J:     state_d = S_JUMP;
                    default:            state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_ADDR: state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (Mem_Ready)  state_d = S_WB_MEM;
                else if (tmo)   state_d = S_TRAP;
            end
            S_MEM_WR: begin
                if (Mem_Ready)  state_d = S_FETCH;
                else if (tmo)   state_d = S_TRAP;
            end
            S_WB_R, S_WB_I, S_WB_MEM,
            S_BRANCH, S_JUMP:   state_d = S_FETCH;
            S_TRAP:             state_d = S_TRAP;
            default:            state_d = S_TRAP;
        endcase
    end

    // Output decode; IR/PC loads are gated off while reset is held.
    always_comb begin
        ALUSrc   = 1'b0;
        ALUOp    = ALU_ADD;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = PC_SEQ;
        Trap     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = Mem_Ready && Reset_n;
                PCWrite = Mem_Ready && Reset_n;
            end
            S_DECODE:   ALUSrc = imm_operand(Opcode);
            S_EXEC_R: begin
                ALUOp = ALU_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ALUSrc = 1'b1;
            end
            S_MEM_RD:   MemRead = 1'b1;
            S_MEM_WR:   MemWrite = 1'b1;
            S_WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_WB_I:     RegWrite = 1'b1;
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_BRANCH: begin
                ALUOp   = ALU_SUB;
                PCWrite = Zero;
                PCSrc   = PC_BR;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PC_JMP;
            end
            S_TRAP:     Trap = 1'b1;
            default:    Trap = 1'b1;
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl.
// Walks each instruction class, timeouts and resets.
module tb_mips_multicycle_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic [5:0] Opcode;
    logic       Zero;
    logic       Mem_Ready;
    logic       ALUSrc;
    logic [1:0] ALUOp;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       Trap;
    logic [3:0] State;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] opb_q;

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .Mem_Ready(Mem_Ready),
        .ALUSrc   (ALUSrc),
        .ALUOp    (ALUOp),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .Trap     (Trap),
        .State    (State)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Registered operand-B mux: imm=2, rd2=1.
    always_ff @(posedge Clk) opb_q <= ALUSrc ? 8'd2 : 8'd1;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Reset_n   = 1'b0;
        Opcode    = 6'b000000;
        Zero      = 1'b0;
        Mem_Ready = 1'b1;
        #3;
        chk("rst_state", 8'(State), 8'd0);
        chk("rst_trap", 8'(Trap), 8'd0);
        chk("rst_memread", 8'(MemRead), 8'd1);
        chk("rst_irwrite", 8'(IRWrite), 8'd0);
        chk("rst_pcwrite", 8'(PCWrite), 8'd0);
        #9 Reset_n = 1'b1;
        #1;
        chk("fetch_irwrite", 8'(IRWrite), 8'd1);
        chk("fetch_pcwrite", 8'(PCWrite), 8'd1);
        chk("fetch_pcsrc", 8'(PCSrc), 8'd0);

        // R-type
        Opcode = 6'b000000;
        tick();
        chk("r_decode", 8'(State), 8'd1);
        chk("r_dec_alusrc", 8'(ALUSrc), 8'd0);
        chk("r_dec_irwrite", 8'(IRWrite), 8'd0);
        tick();
        chk("r_exec", 8'(State), 8'd2);
        chk("r_exec_alusrc", 8'(ALUSrc), 8'd0);
        chk("r_exec_aluop", 8'(ALUOp), 8'd2);
        tick();
        chk("r_wb", 8'(State), 8'd7);
        chk("r_wb_regwrite", 8'(RegWrite), 8'd1);
        chk("r_wb_regdst", 8'(RegDst), 8'd1);
        tick();
        chk("r_done", 8'(State), 8'd0);

        // lw with three wait cycles in MEM_RD
        Opcode = 6'b100011;
        tick();
        chk("lw_dec_alusrc", 8'(ALUSrc), 8'd1);
        tick();
        chk("lw_addr", 8'(State), 8'd4);
        chk("lw_addr_aluop", 8'(ALUOp), 8'd0);
        Mem_Ready = 1'b0;
        tick();
        chk("lw_rd1", 8'(State), 8'd5);
        chk("lw_rd_memread", 8'(MemRead), 8'd1);
        tick();
        tick();
        chk("lw_rd3", 8'(State), 8'd5);
        Mem_Ready = 1'b1;
        tick();
        chk("lw_wb", 8'(State), 8'd9);
        chk("lw_wb_regwrite", 8'(RegWrite), 8'd1);
        chk("lw_wb_memtoreg", 8'(MemtoReg), 8'd1);
        chk("lw_wb_regdst", 8'(RegDst), 8'd0);
        tick();
        chk("lw_done", 8'(State), 8'd0);

        // addi: operand mux loaded from the DECODE select
        Opcode = 6'b001000;
        tick();
        chk("addi_dec_alusrc", 8'(ALUSrc), 8'd1);
        tick();
        chk("addi_exec", 8'(State), 8'd3);
        chk("addi_opb", opb_q, 8'd2);
        chk("addi_exec_alusrc", 8'(ALUSrc), 8'd1);
        tick();
        chk("addi_wb", 8'(State), 8'd8);
        chk("addi_wb_regwrite", 8'(RegWrite), 8'd1);
        chk("addi_wb_memtoreg", 8'(MemtoReg), 8'd0);
        tick();

        // beq taken
        Opcode = 6'b000100;
        Zero   = 1'b1;
        tick();
        tick();
        chk("beq1_state", 8'(State), 8'd10);
        chk("beq1_pcwrite", 8'(PCWrite), 8'd1);
        chk("beq1_pcsrc", 8'(PCSrc), 8'd1);
        chk("beq1_aluop", 8'(ALUOp), 8'd1);
        tick();

        // beq not taken
        Zero = 1'b0;
        tick();
        tick();
        chk("beq0_state", 8'(State), 8'd10);
        chk("beq0_pcwrite", 8'(PCWrite), 8'd0);
        tick();

        // jump
        Opcode = 6'b000010;
        tick();
        tick();
        chk("j_state", 8'(State), 8'd11);
        chk("j_pcwrite", 8'(PCWrite), 8'd1);
        chk("j_pcsrc", 8'(PCSrc), 8'd2);
        tick();
        chk("j_done", 8'(State), 8'd0);

        // sw interrupted by reset
        Opcode = 6'b101011;
        tick();
        tick();
        chk("sw_addr", 8'(State), 8'd4);
        Mem_Ready = 1'b0;
        tick();
        chk("sw_wr", 8'(State), 8'd6);
        chk("sw_memwrite", 8'(MemWrite), 8'd1);
        Reset_n = 1'b0;
        #1;
        chk("sw_rst_memwrite", 8'(MemWrite), 8'd0);
        chk("sw_rst_state", 8'(State), 8'd0);
        #1 Reset_n = 1'b1;

        // fetch timeout
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_pre", 8'(State), 8'd0);
        tick();
        chk("tmo_state", 8'(State), 8'd12);
        chk("tmo_trap", 8'(Trap), 8'd1);
        chk("tmo_memread", 8'(MemRead), 8'd0);
        Mem_Ready = 1'b1;
        tick();
        tick();
        chk("tmo_sticky", 8'(Trap), 8'd1);
        chk("tmo_regwrite", 8'(RegWrite), 8'd0);
        Reset_n = 1'b0;
        #1;
        chk("tmo_rst_trap", 8'(Trap), 8'd0);
        #1 Reset_n = 1'b1;

        // Ready arriving on the timeout cycle completes the access
        Mem_Ready = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        Mem_Ready = 1'b1;
        Opcode    = 6'b111111;
        tick();
        chk("edge_no_trap", 8'(State), 8'd1);
        chk("edge_trap", 8'(Trap), 8'd0);

        // illegal opcode
        tick();
        chk("ill_state", 8'(State), 8'd12);
        chk("ill_trap", 8'(Trap), 8'd1);
        chk("ill_memwrite", 8'(MemWrite), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
